// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with per-lane valid, valid/ready handshake, synchronous flush
// and an optional 2-entry skid buffer that registers in_ready.
module pipe_stage_skid #(
    parameter int LANE_W = 78,
    parameter int LANES  = 1,
    parameter int SKID   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    in_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*LANE_W-1:0] out_data,
    input  logic                    out_ready,
    output logic [1:0]              occupancy
);

    localparam int DW = LANES * LANE_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_r;
    logic [LANES-1:0] head_valid_r;
    logic [DW-1:0]    head_data_r;
    logic [LANES-1:0] skid_valid_r;
    logic [DW-1:0]    skid_data_r;
    logic             in_ready_r;
    logic [1:0]       occ_r;

    logic             in_ready_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [DW-1:0]    in_gated_s;

    // Bubble lanes are stored as zeros so out_data is clean wherever out_valid is low.
    function automatic logic [DW-1:0] gate_lanes(input logic [LANES-1:0] v,
                                                 input logic [DW-1:0]    d);
        logic [DW-1:0] r;
        r = {DW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) begin
                r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
            end else begin
                r[i*LANE_W +: LANE_W] = {LANE_W{1'b0}};
            end
        end
        return r;
    endfunction

    assign in_ready_s = (SKID != 0) ? in_ready_r : (~|head_valid_r | out_ready);
    assign in_fire_s  = in_ready_s & (|in_valid) & ~rst & ~flush;
    assign out_fire_s = (|head_valid_r) & out_ready;
    assign in_gated_s = gate_lanes(in_valid, in_data);

    assign in_ready  = in_ready_s;
    assign out_valid = head_valid_r;
    assign out_data  = head_data_r;
    assign occupancy = occ_r;

    // Stage state machine: head/skid entries, registered in_ready and occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r      <= EMPTY;
            head_valid_r <= {LANES{1'b0}};
            head_data_r  <= {DW{1'b0}};
            skid_valid_r <= {LANES{1'b0}};
            skid_data_r  <= {DW{1'b0}};
            in_ready_r   <= 1'b1;
            occ_r        <= 2'd0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        head_valid_r <= in_valid;
                        head_data_r  <= in_gated_s;
                        state_r      <= ONE;
                        occ_r        <= 2'd1;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        head_valid_r <= in_valid;
                        head_data_r  <= in_gated_s;
                    end else if (in_fire_s) begin
                        // Downstream stalled: park the new word behind the head.
                        skid_valid_r <= in_valid;
                        skid_data_r  <= in_gated_s;
                        in_ready_r   <= 1'b0;
                        state_r      <= FULL;
                        occ_r        <= 2'd2;
                    end else if (out_fire_s) begin
                        head_valid_r <= {LANES{1'b0}};
                        head_data_r  <= {DW{1'b0}};
                        state_r      <= EMPTY;
                        occ_r        <= 2'd0;
                    end else begin
                        state_r <= ONE;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        head_valid_r <= skid_valid_r;
                        head_data_r  <= skid_data_r;
                        skid_valid_r <= {LANES{1'b0}};
                        skid_data_r  <= {DW{1'b0}};
                        in_ready_r   <= 1'b1;
                        state_r      <= ONE;
                        occ_r        <= 2'd1;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    state_r      <= EMPTY;
                    head_valid_r <= {LANES{1'b0}};
                    head_data_r  <= {DW{1'b0}};
                    skid_valid_r <= {LANES{1'b0}};
                    skid_data_r  <= {DW{1'b0}};
                    in_ready_r   <= 1'b1;
                    occ_r        <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default skid build, a 2-lane build and a SKID=0 build.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    // Default build: LANE_W=78, LANES=1, SKID=1
    logic        in_valid = 1'b0;
    logic [77:0] in_data  = 78'd0;
    logic        in_ready;
    logic        out_valid;
    logic [77:0] out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  occupancy;

    // Dual-lane build
    logic [1:0]  in_valid2 = 2'b00;
    logic [31:0] in_data2  = 32'd0;
    logic        in_ready2;
    logic [1:0]  out_valid2;
    logic [31:0] out_data2;
    logic        out_ready2 = 1'b0;
    logic [1:0]  occupancy2;

    // Single-entry build
    logic        in_valid0 = 1'b0;
    logic [77:0] in_data0  = 78'd0;
    logic        in_ready0;
    logic        out_valid0;
    logic [77:0] out_data0;
    logic        out_ready0 = 1'b0;
    logic [1:0]  occupancy0;

    int pass_cnt = 0;
    int total_cnt = 0;

    pipe_stage_skid u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.LANE_W(16), .LANES(2), .SKID(1)) u_dut_l2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .occupancy(occupancy2)
    );

    pipe_stage_skid #(.LANE_W(78), .LANES(1), .SKID(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
        .occupancy(occupancy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;  in_data = 78'h55;
        in_valid2 = 2'b11; in_data2 = 32'h1111_2222;
        in_valid0 = 1'b1; in_data0 = 78'h66;
        out_ready = 1'b0; out_ready2 = 1'b0; out_ready0 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0 || out_data !== 78'd0)
                $display("FAIL reset_out: got valid=%0b data=%0h expected valid=0 data=0", out_valid, out_data);
            else pass_cnt++;
            total_cnt++;
            if (occupancy !== 2'd0 || occupancy2 !== 2'd0 || occupancy0 !== 2'd0)
                $display("FAIL reset_occ: got %0d/%0d/%0d expected 0/0/0", occupancy, occupancy2, occupancy0);
            else pass_cnt++;
        end
        rst = 1'b0;
        in_valid = 1'b0; in_valid2 = 2'b00; in_valid0 = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || in_ready2 !== 1'b1 || in_ready0 !== 1'b1)
            $display("FAIL reset_in_ready: got %0b/%0b/%0b expected 1/1/1", in_ready, in_ready2, in_ready0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || out_valid2 !== 2'b00 || out_valid0 !== 1'b0)
            $display("FAIL reset_no_capture: got %0b/%0b/%0b expected 0/0/0", out_valid, out_valid2, out_valid0);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = 78'(k);
            #1;
            total_cnt++;
            if (in_ready !== 1'b1)
                $display("FAIL stream_in_ready[%0d]: got %0b expected 1", k, in_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 78'(k) || occupancy !== 2'd1)
                $display("FAIL stream_out[%0d]: got valid=%0b data=%0h occ=%0d expected 1/%0h/1",
                         k, out_valid, out_data, occupancy, k);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL stream_drain: got valid=%0b occ=%0d expected 0/0", out_valid, occupancy);
        else pass_cnt++;
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 78'hA;
        tick();
        total_cnt++;
        if (out_data !== 78'hA || occupancy !== 2'd1 || in_ready !== 1'b1)
            $display("FAIL skid_capture_a: got data=%0h occ=%0d rdy=%0b expected a/1/1", out_data, occupancy, in_ready);
        else pass_cnt++;
        in_data = 78'hB;
        tick();
        total_cnt++;
        if (out_data !== 78'hA || occupancy !== 2'd2 || in_ready !== 1'b0)
            $display("FAIL skid_full: got data=%0h occ=%0d rdy=%0b expected a/2/0", out_data, occupancy, in_ready);
        else pass_cnt++;
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 78'hA || occupancy !== 2'd2)
            $display("FAIL skid_stall_hold: got valid=%0b data=%0h occ=%0d expected 1/a/2", out_valid, out_data, occupancy);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++;
        if (out_data !== 78'hB || occupancy !== 2'd1 || in_ready !== 1'b1)
            $display("FAIL skid_pop_a: got data=%0h occ=%0d rdy=%0b expected b/1/1", out_data, occupancy, in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL skid_pop_b: got valid=%0b occ=%0d expected 0/0", out_valid, occupancy);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 78'h11;
        tick();
        in_data = 78'h22;
        tick();
        in_data = 78'h33;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 78'd0 || occupancy !== 2'd0 || in_ready !== 1'b1)
            $display("FAIL flush_full: got valid=%0b data=%0h occ=%0d rdy=%0b expected 0/0/0/1",
                     out_valid, out_data, occupancy, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL flush_no_c[%0d]: got valid=%0b data=%0h expected valid=0", c, out_valid, out_data);
            else pass_cnt++;
        end
        in_valid = 1'b1; in_data = 78'h44;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL flush_drops_in: got valid=%0b occ=%0d expected 0/0", out_valid, occupancy);
        else pass_cnt++;
    endtask

    task automatic test_lanes();
        out_ready2 = 1'b1;
        in_valid2 = 2'b01; in_data2 = {16'hDEAD, 16'h1234};
        tick();
        total_cnt++;
        if (out_valid2 !== 2'b01 || out_data2 !== 32'h0000_1234)
            $display("FAIL lanes_lo: got valid=%0b data=%0h expected 01/00001234", out_valid2, out_data2);
        else pass_cnt++;
        in_valid2 = 2'b10; in_data2 = {16'hBEEF, 16'h5678};
        tick();
        total_cnt++;
        if (out_valid2 !== 2'b10 || out_data2 !== 32'hBEEF_0000)
            $display("FAIL lanes_hi: got valid=%0b data=%0h expected 10/beef0000", out_valid2, out_data2);
        else pass_cnt++;
        in_valid2 = 2'b00;
        tick();
        total_cnt++;
        if (out_valid2 !== 2'b00 || out_data2 !== 32'd0 || occupancy2 !== 2'd0)
            $display("FAIL lanes_empty: got valid=%0b data=%0h occ=%0d expected 00/0/0", out_valid2, out_data2, occupancy2);
        else pass_cnt++;
    endtask

    task automatic test_no_skid();
        int next_send = 1;
        int next_recv = 1;
        int held = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid0  = (c < 8) ? 1'b1 : 1'b0;
            in_data0   = 78'(next_send);
            out_ready0 = (c < 8) ? ((c % 2) == 0) : 1'b1;
            #1;
            total_cnt++;
            if (in_ready0 !== ((held == 0) || out_ready0))
                $display("FAIL noskid_in_ready[%0d]: got %0b expected %0b", c, in_ready0, ((held == 0) || out_ready0));
            else pass_cnt++;
            if (out_valid0 && out_ready0) begin
                total_cnt++;
                if (out_data0 !== 78'(next_recv))
                    $display("FAIL noskid_order: got %0h expected %0h", out_data0, next_recv);
                else pass_cnt++;
                next_recv++;
                held = 0;
            end
            if (in_valid0 && ((held == 0) || out_ready0)) begin
                next_send++;
                held = 1;
            end
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (next_recv != next_send || next_send < 5 || out_valid0 !== 1'b0)
            $display("FAIL noskid_no_loss: got recv=%0d valid=%0b expected recv=%0d valid=0", next_recv, out_valid0, next_send);
        else pass_cnt++;
    endtask

    initial begin
        tick();
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_lanes();
        test_no_skid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
